red_seq: RTL and testbench

- Multi-cycle RED (reduction) unit for area-constrained builds of the 16-bit core.
- Produces the same result as the combinational RED instruction datapath, but shares one adder_4bit over seven sequenced nibble-add steps.
- Driven by the EX-stage stall logic through a start/busy/done handshake; the stall is held while busy is high.

---
 rtl/red_seq_if.sv | 31 +++
 rtl/red_seq.sv | 182 ++++++++++++++++++
 tb/tb_red_seq.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/red_seq_if.sv
// Start/busy/done handshake and operand/result bus for the sequential RED unit.
// The master side issues operations and the slave side is the red_seq datapath.
interface red_seq_if;
  logic        start;
  logic        abort;
  logic [15:0] a_in;
  logic [15:0] b_in;
  logic        busy;
  logic        done;
  logic [15:0] out;

  modport master (
    output start,
    output abort,
    output a_in,
    output b_in,
    input  busy,
    input  done,
    input  out
  );

  modport slave (
    input  start,
    input  abort,
    input  a_in,
    input  b_in,
    output busy,
    output done,
    output out
  );
endinterface

// File: rtl/red_seq.sv
// Multi-cycle RED unit: sums the four signed bytes of A and B into a sign-extended
// 12-bit result by sequencing seven nibble additions through one shared 4-bit adder.
module red_seq #(
  parameter bit CLR_ON_START = 1'b0
) (
  input logic       clk,
  input logic       rst,
  red_seq_if.slave  bus
);

  typedef enum logic [3:0] {
    StIdle,
    StLo0,
    StLo1,
    StHi0,
    StHi1,
    StF0,
    StF1,
    StF2,
    StDone
  } state_e;

  state_e      state_q, state_d;
  logic        accept;

  logic [15:0] a_q, b_q;
  logic [11:0] lo12, hi12, acc;
  logic        c_q;
  logic [15:0] out_q;

  logic [3:0]  add_a, add_b, add_sum;
  logic        add_cin, add_cout, add_ovfl;
  logic [3:0]  ext_nib;

  // Next state; abort beats everything except rst and also blocks a same-cycle start.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StLo0;
          accept  = 1'b1;
        end
      end
      StLo0:  state_d = StLo1;
      StLo1:  state_d = StHi0;
      StHi0:  state_d = StHi1;
      StHi1:  state_d = StF0;
      StF0:   state_d = StF1;
      StF1:   state_d = StF2;
      StF2:   state_d = StDone;
      StDone: begin
        if (bus.start) begin
          state_d = StLo0;
          accept  = 1'b1;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (bus.abort) begin
      state_d = StIdle;
      accept  = 1'b0;
    end
  end

  // Shared adder operand mux; the low nibble of each 8/12-bit add starts with cin = 0.
  always_comb begin
    add_a   = 4'h0;
    add_b   = 4'h0;
    add_cin = 1'b0;
    case (state_q)
      StLo0: begin
        add_a = a_q[3:0];
        add_b = b_q[3:0];
      end
      StLo1: begin
        add_a   = a_q[7:4];
        add_b   = b_q[7:4];
        add_cin = c_q;
      end
      StHi0: begin
        add_a = a_q[11:8];
        add_b = b_q[11:8];
      end
      StHi1: begin
        add_a   = a_q[15:12];
        add_b   = b_q[15:12];
        add_cin = c_q;
      end
      StF0: begin
        add_a = lo12[3:0];
        add_b = hi12[3:0];
      end
      StF1: begin
        add_a   = lo12[7:4];
        add_b   = hi12[7:4];
        add_cin = c_q;
      end
      StF2: begin
        add_a   = lo12[11:8];
        add_b   = hi12[11:8];
        add_cin = c_q;
      end
      default: ;
    endcase
  end

  adder_4bit u_adder (
    .a    (add_a),
    .b    (add_b),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout),
    .ovfl (add_ovfl)
  );

  // On signed byte overflow the true sign is the carry out, otherwise the sum MSB.
  assign ext_nib = add_ovfl ? {4{add_cout}} : {4{add_sum[3]}};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      lo12    <= '0;
      hi12    <= '0;
      acc     <= '0;
      c_q     <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q <= bus.a_in;
        b_q <= bus.b_in;
        c_q <= 1'b0;
        if (CLR_ON_START) begin
          out_q <= '0;
        end
      end else if (!bus.abort) begin
        c_q <= add_cout;
        case (state_q)
          StLo0: lo12[3:0]  <= add_sum;
          StLo1: lo12[11:4] <= {ext_nib, add_sum};
          StHi0: hi12[3:0]  <= add_sum;
          StHi1: hi12[11:4] <= {ext_nib, add_sum};
          StF0:  acc[3:0]   <= add_sum;
          StF1:  acc[7:4]   <= add_sum;
          StF2: begin
            acc[11:8] <= add_sum;
            out_q     <= {{4{add_sum[3]}}, add_sum, acc[7:0]};
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.busy = (state_q != StIdle) && (state_q != StDone);
  assign bus.done = (state_q == StDone);
  assign bus.out  = out_q;

endmodule

// Nibble adder with carry out and signed-overflow flag.
module adder_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout,
  output logic       ovfl
);
  logic [4:0] full;

  assign full = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
  assign sum  = full[3:0];
  assign cout = full[4];
  assign ovfl = (a[3] == b[3]) && (sum[3] != a[3]);
endmodule

// File: tb/tb_red_seq.sv
// Directed bench for red_seq: expected results are queued at start and compared at done.
module tb_red_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  red_seq_if bus0 ();
  red_seq_if bus1 ();

  red_seq #(.CLR_ON_START(1'b0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  red_seq #(.CLR_ON_START(1'b1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  int          n_checks = 0;
  int          n_errs   = 0;
  logic [15:0] sb_q[$];
  logic [15:0] prev;
  int          cnt;

  function automatic logic [15:0] red_model(input logic [15:0] a, input logic [15:0] b);
    logic signed [7:0] a0, a1, b0, b1;
    int s;
    a0 = a[7:0];
    a1 = a[15:8];
    b0 = b[7:0];
    b1 = b[15:8];
    s  = int'(a0) + int'(a1) + int'(b0) + int'(b1);
    return s[15:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_chk(input string tag, input logic [15:0] obs);
    chk({tag, "_sb"}, 32'(sb_q.size() != 0), 32'd1);
    if (sb_q.size() != 0) begin
      chk(tag, 32'(obs), 32'(sb_q.pop_front()));
    end
  endtask

  // Present an op on dut0 for one accepting edge; operands then wander.
  task automatic start0(input logic [15:0] a, input logic [15:0] b, input bit push);
    bus0.a_in  = a;
    bus0.b_in  = b;
    bus0.start = 1'b1;
    if (push) sb_q.push_back(red_model(a, b));
    tick();
    bus0.start = 1'b0;
    bus0.a_in  = 16'($urandom);
    bus0.b_in  = 16'($urandom);
  endtask

  task automatic wait_done0(input string tag);
    int c;
    c = 0;
    while (!bus0.done && c < 40) begin
      tick();
      c++;
    end
    chk({tag, "_done"}, 32'(bus0.done), 32'd1);
    if (bus0.done) pop_chk(tag, bus0.out);
  endtask

  task automatic wait_done1(input string tag);
    int c;
    c = 0;
    while (!bus1.done && c < 40) begin
      tick();
      c++;
    end
    chk({tag, "_done"}, 32'(bus1.done), 32'd1);
    if (bus1.done) pop_chk(tag, bus1.out);
  endtask

  // Full timing check: seven busy cycles, one done cycle, then idle.
  task automatic op_timed0(input string tag, input logic [15:0] a, input logic [15:0] b);
    start0(a, b, 1'b1);
    for (int i = 0; i < 7; i++) begin
      chk({tag, "_busy"}, 32'(bus0.busy), 32'd1);
      chk({tag, "_nodone"}, 32'(bus0.done), 32'd0);
      tick();
    end
    chk({tag, "_done"}, 32'(bus0.done), 32'd1);
    chk({tag, "_done_busy"}, 32'(bus0.busy), 32'd0);
    pop_chk(tag, bus0.out);
    tick();
    chk({tag, "_pulse"}, 32'(bus0.done), 32'd0);
    chk({tag, "_idle"}, 32'(bus0.busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus0.start = 1'b0; bus0.abort = 1'b0; bus0.a_in = '0; bus0.b_in = '0;
    bus1.start = 1'b0; bus1.abort = 1'b0; bus1.a_in = '0; bus1.b_in = '0;

    rst = 1'b1;
    tick();
    tick();
    chk("rst_busy", 32'(bus0.busy), 32'd0);
    chk("rst_done", 32'(bus0.done), 32'd0);
    chk("rst_out", 32'(bus0.out), 32'h0000);
    chk("rst_out1", 32'(bus1.out), 32'h0000);
    rst = 1'b0;
    tick();

    op_timed0("basic", 16'h0102, 16'h0304);
    op_timed0("sat_pos", 16'h7F7F, 16'h7F7F);
    op_timed0("sat_neg", 16'h8080, 16'h8080);
    op_timed0("mix_zero", 16'hFF01, 16'h01FF);
    op_timed0("mix_neg", 16'h80FF, 16'h0000);

    // abort in IDLE swallows a simultaneous start
    bus0.start = 1'b1;
    bus0.abort = 1'b1;
    tick();
    bus0.start = 1'b0;
    bus0.abort = 1'b0;
    chk("abort_idle_busy", 32'(bus0.busy), 32'd0);
    tick();
    chk("abort_idle_still", 32'(bus0.busy), 32'd0);

    // start while busy is ignored
    start0(16'h1111, 16'h2222, 1'b1);
    tick();
    bus0.start = 1'b1;
    bus0.a_in  = 16'h7F7F;
    bus0.b_in  = 16'h7F7F;
    tick();
    bus0.start = 1'b0;
    wait_done0("ignored");
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus0.done) cnt++;
    end
    chk("ignored_one_done", 32'(cnt), 32'd0);
    chk("ignored_sb_empty", 32'(sb_q.size()), 32'd0);

    // back-to-back with start held through DONE
    bus0.a_in  = 16'h0102;
    bus0.b_in  = 16'h0304;
    bus0.start = 1'b1;
    sb_q.push_back(red_model(16'h0102, 16'h0304));
    tick();
    bus0.a_in = 16'h7F7F;
    bus0.b_in = 16'h8080;
    sb_q.push_back(red_model(16'h7F7F, 16'h8080));
    wait_done0("b2b_first");
    tick();
    bus0.start = 1'b0;
    cnt = 1;
    while (!bus0.done && cnt < 20) begin
      tick();
      cnt++;
    end
    chk("b2b_spacing", 32'(cnt), 32'd8);
    chk("b2b_second_done", 32'(bus0.done), 32'd1);
    if (bus0.done) pop_chk("b2b_second", bus0.out);
    tick();
    prev = red_model(16'h7F7F, 16'h8080);

    // abort in HI1
    start0(16'h0505, 16'h0505, 1'b0);
    tick();
    tick();
    tick();
    chk("abort_hi1_busy_before", 32'(bus0.busy), 32'd1);
    bus0.abort = 1'b1;
    tick();
    bus0.abort = 1'b0;
    chk("abort_busy", 32'(bus0.busy), 32'd0);
    chk("abort_done", 32'(bus0.done), 32'd0);
    chk("abort_out", 32'(bus0.out), 32'(prev));
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus0.done) cnt++;
    end
    chk("abort_no_done", 32'(cnt), 32'd0);

    // rst in F1
    start0(16'h0303, 16'h0303, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    chk("rst_f1_busy_before", 32'(bus0.busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_out", 32'(bus0.out), 32'h0000);
    chk("rst_mid_busy", 32'(bus0.busy), 32'd0);
    chk("rst_mid_done", 32'(bus0.done), 32'd0);
    op_timed0("after_rst", 16'h0510, 16'h2001);

    // CLR_ON_START instance
    bus1.a_in  = 16'h7F7F;
    bus1.b_in  = 16'h7F7F;
    bus1.start = 1'b1;
    sb_q.push_back(red_model(16'h7F7F, 16'h7F7F));
    tick();
    bus1.start = 1'b0;
    wait_done1("clr_first");
    tick();
    bus1.a_in  = 16'h0102;
    bus1.b_in  = 16'h0304;
    bus1.start = 1'b1;
    sb_q.push_back(red_model(16'h0102, 16'h0304));
    tick();
    bus1.start = 1'b0;
    chk("clr_busy", 32'(bus1.busy), 32'd1);
    chk("clr_out_cleared", 32'(bus1.out), 32'h0000);
    tick();
    chk("clr_out_held", 32'(bus1.out), 32'h0000);
    wait_done1("clr_second");
    tick();

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
